// File: rtl/synth_seq_defs.sv
// Shared definitions for the synth step sequencer.
// Holds the FSM state encoding, the step-index width helper and the clamp
// rules that turn the raw step/gate/loop inputs into the effective values
// latched at every step start.
package synth_seq_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GATE = 2'd1,
    S_REST = 2'd2
  } seq_state_e;

  // STEP_IDX_W = $clog2(STEPS), kept >= 1 so a port can always be declared.
  function automatic int step_idx_w(int steps);
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

  // A zero step length would never end; treat it as one tick.
  function automatic int unsigned eff_step_f(int unsigned step_len);
    return (step_len == 0) ? 1 : step_len;
  endfunction

  // Gate is capped one tick short of the step so trig always drops
  // before the next step and the envelope retriggers.
  function automatic int unsigned eff_gate_f(int unsigned gate_len,
                                             int unsigned eff_step);
    return (gate_len < eff_step) ? gate_len : eff_step - 1;
  endfunction

  function automatic int unsigned eff_loop_f(int unsigned loop_len,
                                             int unsigned steps);
    if (loop_len == 0)    return 1;
    if (loop_len > steps) return steps;
    return loop_len;
  endfunction

endpackage

// File: rtl/seq_tick_prescaler.sv
// Tick prescaler: counts 0..TICK_DIV-1 while en is high and emits a
// one-cycle tick on the last count. clr restarts the count at 0.
// Ports: clk, rst (sync, active high), clr, en -> tick.
module seq_tick_prescaler #(
  parameter int TICK_DIV = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV <= 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (en)     cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/synth_step_sequencer.sv
// Step sequencer feeding the synth core's trig and osc_count inputs.
// A table of STEPS entries {gate, osc} is played in a loop; each step lasts
// eff_step ticks and holds trig high for the first eff_gate ticks when its
// gate flag is set. One tick = TICK_DIV clks.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   run                      level: 1 play, 0 stop (back to step 0)
//   step_len/gate_len        step and gate durations in ticks
//   loop_len                 number of active steps (clamped 1..STEPS)
//   wr_en/wr_addr/wr_gate/wr_osc  table write port, accepted any time
//   trig, osc_count          to the synth core
//   step_idx, step_strobe    current step and one-cycle step-start pulse
//   playing                  high in GATE or REST
import synth_seq_defs::*;

module synth_step_sequencer #(
  parameter int STEPS    = 8,
  parameter int OSC_W    = 8,
  parameter int TICK_DIV = 10000,
  parameter int LEN_W    = 8,
  localparam int IW      = step_idx_w(STEPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [LEN_W-1:0] step_len,
  input  logic [LEN_W-1:0] gate_len,
  input  logic [IW:0]      loop_len,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_addr,
  input  logic             wr_gate,
  input  logic [OSC_W-1:0] wr_osc,
  output logic             trig,
  output logic [OSC_W-1:0] osc_count,
  output logic [IW-1:0]    step_idx,
  output logic             step_strobe,
  output logic             playing
);

  seq_state_e state_q, state_d;

  logic [STEPS-1:0]            tbl_gate;
  logic [STEPS-1:0][OSC_W-1:0] tbl_osc;

  logic [LEN_W-1:0] tick_cnt;
  logic [LEN_W-1:0] eff_step_q, eff_gate_q;
  logic [LEN_W:0]   tick_nxt;
  logic [LEN_W-1:0] step_eff, gate_eff;
  int unsigned      loop_eff, nxt_idx;
  logic             tick, start;
  logic [IW-1:0]    start_idx;

  seq_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .en   (state_q != S_IDLE),
    .tick (tick)
  );

  // Effective values from the live inputs; only latched on a step start.
  assign step_eff = LEN_W'(eff_step_f(32'(step_len)));
  assign gate_eff = LEN_W'(eff_gate_f(32'(gate_len), 32'(step_eff)));
  assign loop_eff = eff_loop_f(32'(loop_len), STEPS);
  assign tick_nxt = {1'b0, tick_cnt} + 1'b1;
  assign nxt_idx  = 32'(step_idx) + 1;

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    start_idx = '0;
    case (state_q)
      S_IDLE: if (run) start = 1'b1;
      S_GATE: begin
        if (!run)                                    state_d = S_IDLE;
        else if (tick && tick_nxt == {1'b0, eff_gate_q}) state_d = S_REST;
      end
      S_REST: begin
        if (!run) state_d = S_IDLE;
        else if (tick && tick_nxt == {1'b0, eff_step_q}) begin
          start     = 1'b1;
          start_idx = (nxt_idx >= loop_eff) ? '0 : IW'(nxt_idx);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Table is read before this edge's write lands, so a same-edge write
    // to the starting entry plays the old value.
    if (start)
      state_d = (tbl_gate[start_idx] && gate_eff != '0) ? S_GATE : S_REST;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tbl_gate    <= '0;
      tbl_osc     <= '0;
      tick_cnt    <= '0;
      eff_step_q  <= '0;
      eff_gate_q  <= '0;
      step_idx    <= '0;
      osc_count   <= '0;
      step_strobe <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_strobe <= start;
      if (wr_en) begin
        tbl_gate[wr_addr] <= wr_gate;
        tbl_osc[wr_addr]  <= wr_osc;
      end
      if (start) begin
        step_idx   <= start_idx;
        osc_count  <= tbl_osc[start_idx];
        tick_cnt   <= '0;
        eff_step_q <= step_eff;
        eff_gate_q <= gate_eff;
      end else if (state_d == S_IDLE) begin
        step_idx <= '0;                 // osc_count deliberately held
      end else if (tick) begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  assign trig    = (state_q == S_GATE);
  assign playing = (state_q != S_IDLE);

endmodule
